// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package tx_arb_pkg;

  localparam int          N_REQ       = 4;
  localparam int          IDX_W       = $clog2(N_REQ);
  localparam logic [15:0] TIMEOUT_DEF = 16'd50000;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Round-robin pointer to use after serving requester g.
  function automatic idx_t ptr_after(input idx_t g);
    return idx_t'((int'(g) + 1) % N_REQ);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first set Req bit scanning upward from Ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; Valid low when no request is pending.
module rr_select
  import tx_arb_pkg::*;
(
  input  logic [N_REQ-1:0] Req,
  input  idx_t             Ptr,
  output idx_t             Idx,
  output logic             Valid
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    Idx   = '0;
    Valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (Req[(int'(Ptr) + k) % N_REQ]) begin
        Idx   = idx_t'((int'(Ptr) + k) % N_REQ);
        Valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates N_REQ byte requesters onto one UART transmitter (round-robin).
// Latency: Req -> Tx_En_Sig 2 cycles; Tx_Done_Sig -> Ack 1 cycle.
// Backpressure: requesters hold Req until Ack; SEND waits on Tx_Done_Sig
// (bounded by a watchdog when TX_ARB_TIMEOUT_EN is defined).
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int          N_REQ   = tx_arb_pkg::N_REQ,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   Req,
  input  logic [8*N_REQ-1:0] Req_Data,
  output logic [N_REQ-1:0]   Ack,
  output idx_t               Grant_Idx,
  output logic               Busy,
  output logic               Tx_En_Sig,
  output logic [7:0]         Tx_Data,
  input  logic               Tx_Done_Sig,
  output logic               Err
);

  state_t     state_q, state_d;
  idx_t       sel_q, sel_d;      // pick made in IDLE, consumed by LOAD
  idx_t       grant_q, grant_d;
  idx_t       ptr_q, ptr_d;
  logic [7:0] data_q, data_d;
  idx_t       rr_idx;
  logic       rr_vld;

  rr_select u_rr (
    .Req   (Req),
    .Ptr   (ptr_q),
    .Idx   (rr_idx),
    .Valid (rr_vld)
  );

`ifdef TX_ARB_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        to_q, to_d;       // current byte ended by watchdog, not Tx_Done_Sig
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Next-state, datapath capture and Moore outputs.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    Ack       = '0;
    Tx_En_Sig = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
    wdog_d    = wdog_q;
    to_d      = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rr_vld) begin
          sel_d   = rr_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        grant_d = sel_q;
        data_d  = Req_Data[8*sel_q +: 8];
        state_d = ST_SEND;
`ifdef TX_ARB_TIMEOUT_EN
        wdog_d  = '0;
        to_d    = 1'b0;
`endif
      end
      ST_SEND: begin
        Tx_En_Sig = 1'b1;
        if (Tx_Done_Sig) begin
          state_d = ST_DONE;
`ifdef TX_ARB_TIMEOUT_EN
        end else if (wdog_q == TIMEOUT - 16'd1) begin
          state_d = ST_DONE;
          to_d    = 1'b1;
        end else begin
          wdog_d  = wdog_q + 16'd1;
`endif
        end
      end
      ST_DONE: begin
        ptr_d   = ptr_after(grant_q);
        state_d = ST_IDLE;
`ifdef TX_ARB_TIMEOUT_EN
        if (!to_q) Ack[grant_q] = 1'b1;
`else
        Ack[grant_q] = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      data_q  <= 8'h00;
`ifdef TX_ARB_TIMEOUT_EN
      wdog_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
`ifdef TX_ARB_TIMEOUT_EN
      wdog_q  <= wdog_d;
      to_q    <= to_d;
`endif
    end
  end

  assign Grant_Idx = grant_q;
  assign Tx_Data   = data_q;
  assign Busy      = (state_q != ST_IDLE);
`ifdef TX_ARB_TIMEOUT_EN
  assign Err       = (state_q == ST_DONE) && to_q;
`else
  assign Err       = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus randomized
// request traffic checked against a round-robin reference model.
// TX_ARB_TIMEOUT_EN enables the watchdog scenario.
module tb_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  Req;
  logic [31:0] Req_Data;
  logic [3:0]  Ack;
  logic [1:0]  Grant_Idx;
  logic        Busy;
  logic        Tx_En_Sig;
  logic [7:0]  Tx_Data;
  logic        Tx_Done_Sig;
  logic        Err;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;   // model round-robin pointer

  tx_arbiter #(.N_REQ(4), .TIMEOUT(16'd100)) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .Req_Data(Req_Data), .Ack(Ack),
    .Grant_Idx(Grant_Idx), .Busy(Busy), .Tx_En_Sig(Tx_En_Sig),
    .Tx_Data(Tx_Data), .Tx_Done_Sig(Tx_Done_Sig), .Err(Err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, limit 2ms");
    $fatal(1);
  end

  // Reference: first requesting index at or after p, wrapping.
  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; Req = 4'b0; Tx_Done_Sig = 1'b0;
    tick(); tick();
    RST = 1'b0;
    ptr_m = 0;
  endtask

  task automatic wait_tx_en(input string tag, output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    while (cyc < 20) begin
      if (Tx_En_Sig === 1'b1) begin ok = 1'b1; break; end
      tick(); cyc++;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_txen: Tx_En_Sig=%b after %0d cycles, want 1", tag, Tx_En_Sig, cyc);
    end
  endtask

  // Serve one byte: model predicts the grant, bench plays the transmitter.
  task automatic serve_one(input string tag, input bit clear_served, input int hold, output int got);
    int exp, cyc;
    bit ok;
    logic [7:0] exp_dat;
    logic [3:0] exp_ack;
    got = -1;
    exp = model_pick(Req, ptr_m);
    exp_dat = Req_Data[8*exp +: 8];
    wait_tx_en(tag, cyc, ok);
    if (!ok) return;
    got = int'(Grant_Idx);
    checks++;
    if (Grant_Idx !== 2'(exp)) begin
      failures++; $display("FAIL %s_grant: got %0d want %0d", tag, Grant_Idx, exp);
    end
    checks++;
    if (Tx_Data !== exp_dat) begin
      failures++; $display("FAIL %s_data: got %h want %h", tag, Tx_Data, exp_dat);
    end
    repeat (hold) tick();
    checks++;
    if (Tx_En_Sig !== 1'b1 || Ack !== 4'b0) begin
      failures++; $display("FAIL %s_hold: en=%b ack=%b want en=1 ack=0000", tag, Tx_En_Sig, Ack);
    end
    Tx_Done_Sig = 1'b1;
    tick();
    Tx_Done_Sig = 1'b0;
    exp_ack = 4'b0001 << exp;
    checks++;
    if (Ack !== exp_ack || Tx_En_Sig !== 1'b0 || Err !== 1'b0) begin
      failures++;
      $display("FAIL %s_ack: ack=%b en=%b err=%b want ack=%b en=0 err=0", tag, Ack, Tx_En_Sig, Err, exp_ack);
    end
    ptr_m = (exp + 1) % 4;
    if (clear_served) Req[exp] = 1'b0;
    tick();
    checks++;
    if (Ack !== 4'b0 || Tx_En_Sig !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_gap: ack=%b en=%b busy=%b want 0000/0/0", tag, Ack, Tx_En_Sig, Busy);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; Req = 4'b1111; Req_Data = 32'hDEADBEEF; Tx_Done_Sig = 1'b0;
    tick(); tick();
    checks++;
    if (Ack !== 4'b0 || Busy !== 1'b0 || Tx_En_Sig !== 1'b0 || Err !== 1'b0) begin
      failures++; $display("FAIL reset_ctl: ack=%b busy=%b en=%b err=%b want all 0", Ack, Busy, Tx_En_Sig, Err);
    end
    checks++;
    if (Grant_Idx !== 2'd0 || Tx_Data !== 8'h00) begin
      failures++; $display("FAIL reset_dat: grant=%0d data=%h want 0/00", Grant_Idx, Tx_Data);
    end
    Req = 4'b0;
    RST = 1'b0;
    ptr_m = 0;
    tick();
  endtask

  task automatic test_single();
    Req_Data = 32'h00A50000; Req = 4'b0100;
    tick();
    checks++;
    if (Tx_En_Sig !== 1'b0 || Busy !== 1'b1) begin
      failures++; $display("FAIL single_load: en=%b busy=%b want 0/1", Tx_En_Sig, Busy);
    end
    tick();
    checks++;
    if (Tx_En_Sig !== 1'b1 || Tx_Data !== 8'hA5 || Grant_Idx !== 2'd2) begin
      failures++; $display("FAIL single_send: en=%b data=%h grant=%0d want 1/a5/2", Tx_En_Sig, Tx_Data, Grant_Idx);
    end
    Tx_Done_Sig = 1'b1; tick(); Tx_Done_Sig = 1'b0;
    checks++;
    if (Ack !== 4'b0100) begin
      failures++; $display("FAIL single_ack: got %b want 0100", Ack);
    end
    ptr_m = 3;
    Req = 4'b0;
    tick();
    checks++;
    if (Ack !== 4'b0 || Busy !== 1'b0) begin
      failures++; $display("FAIL single_idle: ack=%b busy=%b want 0000/0", Ack, Busy);
    end
  endtask

  task automatic test_contention();
    int order[5] = '{0, 1, 2, 3, 0};
    int got;
    do_reset();
    Req_Data = 32'h13121110; Req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve_one("contention", 1'b0, int'($urandom_range(0, 3)), got);
      checks++;
      if (got !== order[i]) begin
        failures++; $display("FAIL contention_order%0d: got %0d want %0d", i, got, order[i]);
      end
    end
    Req = 4'b0;
    tick(); tick();
  endtask

  task automatic test_fairness();
    int got;
    Req_Data = 32'h44332211;
    Req = 4'b0010;
    serve_one("fair_setup", 1'b1, 0, got);   // pointer now 2
    Req = 4'b0011;
    serve_one("fair_first", 1'b1, 1, got);
    checks++;
    if (got !== 0) begin failures++; $display("FAIL fair_first_idx: got %0d want 0", got); end
    serve_one("fair_second", 1'b1, 0, got);
    checks++;
    if (got !== 1) begin failures++; $display("FAIL fair_second_idx: got %0d want 1", got); end
    tick();
  endtask

  task automatic test_inflight();
    int cyc;
    bit ok;
    Req_Data = 32'h0000003C; Req = 4'b0001;
    wait_tx_en("inflight", cyc, ok);
    Req_Data = 32'h000000FF; Req = 4'b0000;
    tick(); tick();
    checks++;
    if (Tx_Data !== 8'h3C || Tx_En_Sig !== 1'b1) begin
      failures++; $display("FAIL inflight_data: data=%h en=%b want 3c/1", Tx_Data, Tx_En_Sig);
    end
    Tx_Done_Sig = 1'b1; tick(); Tx_Done_Sig = 1'b0;
    checks++;
    if (Ack !== 4'b0001) begin failures++; $display("FAIL inflight_ack: got %b want 0001", Ack); end
    ptr_m = (model_pick(4'b0001, ptr_m) + 1) % 4;
    tick();
  endtask

  task automatic test_spurious();
    int got;
    Req = 4'b0;
    Tx_Done_Sig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Busy !== 1'b0 || Ack !== 4'b0 || Tx_En_Sig !== 1'b0) begin
        failures++; $display("FAIL spurious_%0d: busy=%b ack=%b en=%b want 0/0000/0", i, Busy, Ack, Tx_En_Sig);
      end
    end
    Tx_Done_Sig = 1'b0;
    Req_Data = 32'h9A000077; Req = 4'b1001;
    serve_one("spurious_after", 1'b1, 0, got);
    Req = 4'b0;
    tick();
  endtask

  task automatic test_reset_mid_send();
    int cyc;
    bit ok;
    Req_Data = 32'h000000C3; Req = 4'b0001;
    wait_tx_en("rstmid", cyc, ok);
    RST = 1'b1;
    tick();
    checks++;
    if (Tx_En_Sig !== 1'b0 || Ack !== 4'b0 || Busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_drop: en=%b ack=%b busy=%b want 0/0000/0", Tx_En_Sig, Ack, Busy);
    end
    Req = 4'b0;
    tick();
    RST = 1'b0;
    ptr_m = 0;
    tick();
    checks++;
    if (Ack !== 4'b0 || Tx_Data !== 8'h00 || Busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_after: ack=%b data=%h busy=%b want 0000/00/0", Ack, Tx_Data, Busy);
    end
  endtask

  task automatic test_random();
    logic [3:0] newbits;
    int got;
    Req = 4'b0;
    for (int it = 0; it < 30; it++) begin
      newbits = 4'($urandom_range(0, 15)) & ~Req;
      if ((Req | newbits) == 4'b0) newbits = 4'b0001 << $urandom_range(0, 3);
      for (int b = 0; b < 4; b++)
        if (newbits[b]) Req_Data[8*b +: 8] = 8'($urandom);
      Req = Req | newbits;
      serve_one("random", 1'b1, int'($urandom_range(0, 4)), got);
    end
    Req = 4'b0;
    tick(); tick();
  endtask

`ifdef TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, n, got;
    bit ok;
    do_reset();
    Req_Data = 32'h00CC5500; Req = 4'b0010;
    wait_tx_en("timeout", cyc, ok);
    n = 1;
    while (Err !== 1'b1 && n < 200) begin
      tick();
      if (Tx_En_Sig === 1'b1) n++;
    end
    checks++;
    if (Err !== 1'b1 || n !== 100 || Ack !== 4'b0) begin
      failures++; $display("FAIL timeout_err: err=%b send_cycles=%0d ack=%b want 1/100/0000", Err, n, Ack);
    end
    ptr_m = 2;
    tick();
    Req = 4'b0110;
    serve_one("timeout_next", 1'b1, 0, got);
    checks++;
    if (got !== 2) begin failures++; $display("FAIL timeout_next_idx: got %0d want 2", got); end
    Req = 4'b0;
    tick();
  endtask
`endif

  initial begin
    RST = 1'b1; Req = 4'b0; Req_Data = 32'b0; Tx_Done_Sig = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_inflight();
    test_spurious();
    test_reset_mid_send();
    test_random();
`ifdef TX_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Ack must never have more than one bit set.
  always @(negedge CLK) begin
    if (!RST && !$onehot0(Ack)) begin
      failures++;
      $display("FAIL ack_onehot: got %b want one-hot or zero", Ack);
    end
  end

endmodule
